// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RISC-V funct3 width codes and the request legality check.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // A request is in error when its width code is not legal for its
    // direction, or when a halfword/word access is not naturally aligned.
    function automatic logic lsu_is_err(input logic       i_we,
                                        input logic [2:0] i_funct3,
                                        input logic [1:0] i_off);
        logic w_illegal;
        logic w_misaligned;
        if (i_we) begin
            w_illegal = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W));
        end else begin
            w_illegal = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
        end
        // Unsigned variants share the low two bits with their signed forms.
        w_misaligned = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
        return w_illegal || w_misaligned;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the core-side request/response handshake and the data-memory
// strobe bus. The master modport is the LSU itself; slave is its environment.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, readdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               memread, memwrite, addr, writedata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, readdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               memread, memwrite, addr, writedata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges sub-word store data into the word read back for RMW.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword lanes out of the memory word.
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Sign- or zero-extend the selected lane according to the load width.
    always_comb begin
        o_load = i_rdata;
        case (i_funct3)
            F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load = {24'h0, w_byte};
            F3_H:    o_load = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load = {16'h0, w_half};
            default: o_load = i_rdata;
        endcase
    end

    // Overlay the low store bits onto the addressed lane of the old word.
    always_comb begin
        o_merged = i_rdata;
        case (i_funct3)
            F3_B: begin
                case (i_off)
                    2'd0: o_merged[7:0]   = i_wdata[7:0];
                    2'd1: o_merged[15:8]  = i_wdata[7:0];
                    2'd2: o_merged[23:16] = i_wdata[7:0];
                    2'd3: o_merged[31:24] = i_wdata[7:0];
                    default: o_merged = i_rdata;
                endcase
            end
            F3_H: begin
                if (i_off[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0]  = i_wdata[15:0];
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Load/store unit master: accepts one core request at a time, performs the
// word read, read-modify-write or word write on the data memory, and returns
// a single-cycle response. Address decode is left entirely to the memory side.
module lsu_master
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.master bus
);

    lsu_state_t  r_state;
    lsu_state_t  w_next;

    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wword;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept = bus.req_valid && (r_state == IDLE);
    assign w_err    = lsu_is_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[1:0]),
        .i_rdata  (bus.readdata),
        .i_wdata  (r_wword),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: the request kind decides the path at accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next = RESP;
                    end else if (!bus.req_we) begin
                        w_next = READ;
                    end else if (bus.req_funct3 == F3_W) begin
                        w_next = WRITE;
                    end else begin
                        w_next = RMW_READ;
                    end
                end
            end
            READ:     w_next = RESP;
            RMW_READ: w_next = WRITE;
            WRITE:    w_next = RESP;
            RESP:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Request latches, load result capture and store-word merge capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wword  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_addr;
                r_wword  <= bus.req_wdata;
                r_rdata  <= 32'h0;
                r_err    <= w_err;
            end
            if (r_state == READ) begin
                r_rdata <= w_load;
            end
            // SW keeps the latched word; SB/SH replace it with the merge.
            if (r_state == RMW_READ) begin
                r_wword <= w_merged;
            end
        end
    end

    // Output decode; strobes and response are suppressed while rst is high.
    always_comb begin
        bus.req_ready  = (r_state == IDLE);
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.addr       = 32'h0;
        bus.writedata  = 32'h0;
        case (r_state)
            READ, RMW_READ: begin
                bus.memread = !rst;
                bus.addr    = {r_addr[31:2], 2'b00};
            end
            WRITE: begin
                bus.memwrite  = !rst;
                bus.addr      = {r_addr[31:2], 2'b00};
                bus.writedata = r_wword;
            end
            RESP: begin
                bus.resp_valid = !rst;
                bus.resp_rdata = r_rdata;
                bus.resp_err   = r_err;
            end
            default: begin
                bus.req_ready = (r_state == IDLE);
            end
        endcase
    end

endmodule
